ss_adc_readout: RTL and testbench
=================================

Name: ss_adc_readout

Overview:
- Consumer end of the per-pixel comparator edge-detect interface in the single-slope ADC path.
- Runs one conversion: gates the ramp and drives a shared ramp counter.
- On each pixel's one-cycle enable pulse, latches the current count as that pixel's digital code.
- After the conversion, streams all codes out, pixel 0 first, over a valid/ready interface.

Parameters:
NUM_PIXELS, 50, number of pixel columns; width of the enable input.
COUNT_WIDTH, 10, ramp counter and code width. Full scale MAX_COUNT = 2^COUNT_WIDTH - 1.
PIX_W, $clog2(NUM_PIXELS), pixel index width (derived; must not be overridden).

Ports:
clk  input  1  system clock, all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request a conversion. Sampled only in IDLE.
enable  input  NUM_PIXELS  per-pixel rising-edge pulses from the edge detector.
ramp_en  output  1  high while the ramp runs (CONVERT state).
count  output  COUNT_WIDTH  current ramp count.
busy  output  1  high in CONVERT or READOUT.
out_valid  output  1  readout data valid.
out_ready  input  1  downstream accepts data.
out_data  output  COUNT_WIDTH  code of the pixel at out_pixel.
out_pixel  output  PIX_W  index of the pixel being presented.
done  output  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; count = 0; all codes = 0; latched mask = 0.
  - ramp_en, busy, out_valid, done = 0; out_pixel = 0.
  - Asserting reset mid-conversion or mid-readout aborts immediately. No done pulse is produced.
- FSM states: IDLE, CONVERT, READOUT. All outputs are registered.
- IDLE:
  - start=1 at edge E: at E, state <= CONVERT, count <= 0, latched mask <= 0.
  - From the cycle after E: ramp_en=1, busy=1, count=0.
  - start is ignored in every other state.
- CONVERT:
  - Each cycle, for every i with enable[i]=1 and latched[i]=0: code[i] <= count and latched[i] <= 1.
  - An enable on an already-latched pixel is ignored; the first edge wins.
  - Multiple pixels pulsing in the same cycle all capture the same count.
  - count increments by 1 per cycle. It does not wrap within a conversion.
  - Exit when count == MAX_COUNT, or when all pixels are latched (including captures this cycle), whichever is first. Next state is READOUT, and ramp_en drops on the same edge.
  - Pixels still unlatched at exit get code = MAX_COUNT (saturated).
  - An enable arriving in the same cycle that count == MAX_COUNT is captured as MAX_COUNT.
- READOUT:
  - First READOUT cycle: out_valid=1, out_pixel=0, out_data=code[0].
  - Handshake is an edge where out_valid && out_ready.
  - out_data and out_pixel are held stable while out_valid=1 and out_ready=0.
  - On handshake with out_pixel < NUM_PIXELS-1: advance to the next pixel with no bubble. out_valid stays 1.
  - On handshake at pixel NUM_PIXELS-1: out_valid <= 0, done <= 1 for exactly one cycle, busy <= 0, state <= IDLE, count <= 0.
  - enable pulses during READOUT and IDLE are ignored.
- Sustained throughput: one code per cycle with out_ready held high. Total readout is NUM_PIXELS cycles.
- start held high through done begins a new conversion on the first IDLE cycle, which is the done cycle.

Test Plan:
- Reset behaviour: NUM_PIXELS=4, COUNT_WIDTH=4. Assert reset during CONVERT at count=7 -> outputs 0 immediately. After release: state IDLE, no done pulse.
- Basic conversion (NUM_PIXELS=4, COUNT_WIDTH=4): start, then pulse enable[2] at count=3, [0] at count=9, [1] and [3] at count=12 -> exit after the count-12 cycle. Stream order 9,12,3,12 with pixels 0..3, then done pulse.
- Saturation and duplicate edges: enable[1] pulsed at count=5 and again at count=8; others never pulse -> codes MAX_COUNT=15, 5, 15, 15. ramp_en is high for exactly 16 cycles (count 0..15).
- Backpressure: out_ready low for 3 cycles during pixel 1 -> out_data and out_pixel stable, no skipped or duplicated pixel. With out_ready always 1 -> exactly 4 valid cycles back-to-back.
- Edge at boundary: enable[0] at count=15 -> code 15. start pulses during CONVERT and READOUT -> ignored, count not restarted.
- Default parameters (50 pixels, 10 bits): random unique enable counts -> all 50 codes match, out_pixel runs 0..49, done is high for 1 cycle.

Source files
------------

// File: rtl/ss_adc_readout.sv
// Single-slope ADC readout: runs the shared ramp counter, captures per-pixel codes
// on comparator edge pulses, then streams the codes out over valid/ready.
module ss_adc_readout #(
  parameter int NUM_PIXELS  = 50,
  parameter int COUNT_WIDTH = 10,
  localparam int PIX_W      = $clog2(NUM_PIXELS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PIXELS-1:0]  enable,
  output logic                   ramp_en,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_data,
  output logic [PIX_W-1:0]       out_pixel,
  output logic                   done
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;
  localparam logic [PIX_W-1:0]       LAST_PIX  = PIX_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, READOUT} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [NUM_PIXELS-1:0]  latched_q, latched_d;
  logic [COUNT_WIDTH-1:0] codes_q [NUM_PIXELS];
  logic [COUNT_WIDTH-1:0] codes_d [NUM_PIXELS];
  logic                   ramp_en_q, ramp_en_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [PIX_W-1:0]       pixel_q, pixel_d;
  logic [COUNT_WIDTH-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic [PIX_W-1:0]       pixel_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      latched_q <= '0;
      codes_q   <= '{default: '0};
      ramp_en_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pixel_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      latched_q <= latched_d;
      codes_q   <= codes_d;
      ramp_en_q <= ramp_en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      pixel_q   <= pixel_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    latched_d = latched_q;
    codes_d   = codes_q;
    ramp_en_d = ramp_en_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    pixel_d   = pixel_q;
    data_d    = data_q;
    done_d    = 1'b0;
    pixel_nxt = pixel_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CONVERT;
          count_d   = '0;
          latched_d = '0;
          ramp_en_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      CONVERT: begin
        // First edge wins: only still-unlatched pixels capture the count.
        for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
          if (enable[i] && !latched_q[i]) begin
            codes_d[i]   = count_q;
            latched_d[i] = 1'b1;
          end
        end
        if (count_q != MAX_COUNT) count_d = count_q + 1'b1;
        if (count_q == MAX_COUNT || &latched_d) begin
          // Saturate pixels that never fired, then present pixel 0 from the merged codes.
          for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
            if (!latched_d[i]) codes_d[i] = MAX_COUNT;
          end
          state_d   = READOUT;
          ramp_en_d = 1'b0;
          valid_d   = 1'b1;
          pixel_d   = '0;
          data_d    = codes_d[0];
        end
      end

      READOUT: begin
        if (valid_q && out_ready) begin
          if (pixel_q == LAST_PIX) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            count_d = '0;
          end else begin
            pixel_d = pixel_nxt;
            data_d  = codes_q[pixel_nxt];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign ramp_en   = ramp_en_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pixel = pixel_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ss_adc_readout.sv
// Bench for ss_adc_readout: a 4-pixel/4-bit instance and a default 50-pixel/10-bit
// instance, checked against a pulse-schedule reference model.
module tb_ss_adc_readout;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        out_ready;
  logic [49:0] en;
  bit          sel;  // 0 = small instance, 1 = default instance

  logic       s_ramp, s_busy, s_valid, s_done;
  logic [3:0] s_count, s_data;
  logic [1:0] s_pixel;
  logic       b_ramp, b_busy, b_valid, b_done;
  logic [9:0] b_count, b_data;
  logic [5:0] b_pixel;

  logic [31:0] o_ramp, o_busy, o_valid, o_done, o_count, o_data, o_pixel;

  int checks = 0;
  int errors = 0;
  int np, maxc, exit_k;
  int p1 [50];
  int p2 [50];
  int exp_code [50];

  always #5 clk = ~clk;

  ss_adc_readout #(.NUM_PIXELS(4), .COUNT_WIDTH(4)) u_small (
    .clk(clk), .reset(reset), .start(start & ~sel), .enable(sel ? 4'b0 : en[3:0]),
    .ramp_en(s_ramp), .count(s_count), .busy(s_busy), .out_valid(s_valid),
    .out_ready(out_ready), .out_data(s_data), .out_pixel(s_pixel), .done(s_done)
  );

  ss_adc_readout u_big (
    .clk(clk), .reset(reset), .start(start & sel), .enable(sel ? en : 50'b0),
    .ramp_en(b_ramp), .count(b_count), .busy(b_busy), .out_valid(b_valid),
    .out_ready(out_ready), .out_data(b_data), .out_pixel(b_pixel), .done(b_done)
  );

  always_comb begin
    o_ramp  = sel ? 32'(b_ramp)  : 32'(s_ramp);
    o_busy  = sel ? 32'(b_busy)  : 32'(s_busy);
    o_valid = sel ? 32'(b_valid) : 32'(s_valid);
    o_done  = sel ? 32'(b_done)  : 32'(s_done);
    o_count = sel ? 32'(b_count) : 32'(s_count);
    o_data  = sel ? 32'(b_data)  : 32'(s_data);
    o_pixel = sel ? 32'(b_pixel) : 32'(s_pixel);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Code of each pixel is its earliest pulse; conversion ends at the latest first
  // pulse if every pixel fired, otherwise at full scale with the rest saturated.
  task automatic model();
    bit all_fired = 1'b1;
    int last = 0;
    for (int i = 0; i < np; i++) begin
      int f = -1;
      if (p1[i] >= 0 && p1[i] <= maxc) f = p1[i];
      if (p2[i] >= 0 && p2[i] <= maxc && (f < 0 || p2[i] < f)) f = p2[i];
      if (f < 0) begin
        all_fired = 1'b0;
        exp_code[i] = maxc;
      end else begin
        exp_code[i] = f;
        if (f > last) last = f;
      end
    end
    exit_k = all_fired ? last : maxc;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 50; i++) begin
      p1[i] = -1;
      p2[i] = -1;
    end
  endtask

  task automatic do_convert(input bit poke_start);
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k <= exit_k; k++) begin
      if (k > 0) @(negedge clk);
      chk("ramp_en_convert", o_ramp, 1);
      chk("busy_convert", o_busy, 1);
      chk("count_convert", o_count, 32'(k));
      chk("valid_convert", o_valid, 0);
      en = '0;
      for (int i = 0; i < np; i++) if (p1[i] == k || p2[i] == k) en[i] = 1'b1;
      start = poke_start && (k == 4);
    end
    @(negedge clk);
    en = '0;
    start = 1'b0;
    chk("ramp_en_after_exit", o_ramp, 0);
    chk("valid_first", o_valid, 1);
    chk("pixel_first", o_pixel, 0);
    chk("busy_readout", o_busy, 1);
  endtask

  // start_mode: 0 none, 1 single pulse in first readout cycle, 2 held through done
  task automatic do_readout(input int stall_pix, input int stall_len, input bit rnd,
                            input int start_mode);
    int p = 0;
    int cyc = 0;
    int stalled = 0;
    bit rdy;
    while (p < np && cyc < 20 * np + 100) begin
      if (cyc > 0) @(negedge clk);
      chk("valid_readout", o_valid, 1);
      chk("pixel_readout", o_pixel, 32'(p));
      chk("data_readout", o_data, 32'(exp_code[p]));
      chk("done_early", o_done, 0);
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else if (p == stall_pix && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end else rdy = 1'b1;
      start = (start_mode == 2) || (start_mode == 1 && cyc == 0);
      out_ready = rdy;
      if (rdy) p++;
      cyc++;
    end
    chk("readout_in_budget", 32'(p), 32'(np));
    if (!rnd) chk("readout_cycles", 32'(cyc), 32'(np + stall_len));
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_pulse", o_done, 1);
    chk("valid_at_done", o_valid, 0);
    chk("busy_at_done", o_busy, 0);
    chk("count_at_done", o_count, 0);
    if (start_mode != 2) begin
      @(negedge clk);
      chk("done_one_cycle", o_done, 0);
      chk("busy_idle", o_busy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ramp"}, o_ramp, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pixel"}, o_pixel, 0);
  endtask

  initial begin
    bit used [1024];
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; en = '0; sel = 1'b0;
    np = 4; maxc = 15;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;

    // Abort mid-conversion at count 7
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    chk("count_before_abort", o_count, 7);
    reset = 1'b0;
    #1 check_all_zero("async_abort");
    @(negedge clk); reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("idle_after_abort");
    end

    // Basic conversion
    clear_sched();
    p1[2] = 3; p1[0] = 9; p1[1] = 12; p1[3] = 12;
    do_convert(1'b0);
    do_readout(-1, 0, 1'b0, 0);

    // Saturation with duplicate edge, plus backpressure on pixel 1
    clear_sched();
    p1[1] = 5; p2[1] = 8;
    do_convert(1'b0);
    do_readout(1, 3, 1'b0, 0);

    // Boundary capture at full scale; stray start pulses ignored
    clear_sched();
    p1[0] = 15;
    do_convert(1'b1);
    do_readout(-1, 0, 1'b0, 1);

    // start held through done restarts on the done cycle
    clear_sched();
    p1[0] = 1; p1[1] = 2; p1[2] = 2; p1[3] = 6;
    do_convert(1'b0);
    do_readout(2, 2, 1'b0, 2);
    @(negedge clk);
    start = 1'b0;
    chk("restart_ramp", o_ramp, 1);
    chk("restart_busy", o_busy, 1);
    chk("restart_count", o_count, 0);
    chk("restart_done_low", o_done, 0);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Default instance: random unique counts, then random saturating schedule
    sel = 1'b1; np = 50; maxc = 1023;
    @(negedge clk);
    check_all_zero("big_idle");
    for (int run = 0; run < 2; run++) begin
      clear_sched();
      for (int v = 0; v < 1024; v++) used[v] = 1'b0;
      for (int i = 0; i < 50; i++) begin
        int v;
        do v = int'($urandom_range(0, 1023)); while (used[v]);
        used[v] = 1'b1;
        p1[i] = v;
        if (run == 1 && (i % 7) == 3) p2[i] = int'($urandom_range(0, 1023));
        if (run == 1 && (i % 16) == 5) p1[i] = -1;
      end
      do_convert(1'b0);
      do_readout(-1, 0, 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
